util_dac_sample_buf: RTL
========================

Name: util_dac_sample_buf

Overview:
Elastic sample buffer directly downstream of util_fir_int on the TX path.
- Captures the interpolator's {channel_1, channel_0} output whenever m_axis_data_tvalid is high.
- Re-times samples to a fixed DAC sample strobe derived from aclk.
- Drives dac_read back to the interpolator as level-based flow control.
- Reports underflow and overflow through sticky status bits.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries of 32 bits.
RATE_DIV, 8, aclk cycles per DAC sample strobe; legal range 2..255.
PREFILL, 4, minimum fill level required before output starts or resumes; legal range 1..2**DEPTH_LOG2.
HIGH_WM, 12, dac_read is deasserted when level >= HIGH_WM; must be <= 2**DEPTH_LOG2.

Ports:
aclk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  run enable; low flushes the FIFO and idles the block
in_valid  in  1  connected to util_fir_int m_axis_data_tvalid
in_ch0  in  16  connected to util_fir_int channel_0
in_ch1  in  16  connected to util_fir_int channel_1
dac_read  out  1  request to util_fir_int; high when level < HIGH_WM and enable=1
dac_valid  out  1  one-cycle pulse per DAC strobe while streaming
dac_data_0  out  16  registered channel 0 sample
dac_data_1  out  16  registered channel 1 sample
level  out  DEPTH_LOG2+1  current FIFO occupancy
underflow  out  1  sticky; set when a strobe finds the FIFO empty
overflow  out  1  sticky; set when a write is attempted while the FIFO is full
clr_status  in  1  one-cycle clear of underflow and overflow

Behaviour:
- Reset (reset=1): state=IDLE, FIFO pointers=0, level=0, rate counter=0, dac_valid=0, dac_data_0/1=0, underflow=0, overflow=0, dac_read=0.
- Write path:
  - When in_valid=1, enable=1 and FIFO not full, push {in_ch1, in_ch0} on that edge.
  - When the FIFO is full, the write is dropped and overflow is set on that edge.
  - in_valid is ignored while enable=0.
- Level: registered and updated one cycle after a push or pop. A simultaneous push and pop leaves level unchanged, including at full, where the push is accepted because the pop frees the slot.
- Rate counter:
  - Free-runs 0..RATE_DIV-1 only in states PREFILL, RUN and UNDERRUN; held at 0 in IDLE.
  - strobe = (counter == RATE_DIV-1).
- State machine:
  - IDLE: entered when enable=0 from any state, with the FIFO flushed on that edge. Moves to PREFILL when enable=1.
  - PREFILL: no output. Moves to RUN when level >= PREFILL; the counter restarts at 0 on entry to RUN.
  - RUN: on each strobe with the FIFO non-empty, pop, register the sample into dac_data_0/1 and pulse dac_valid one cycle later (latency of 1 cycle from strobe). On a strobe with the FIFO empty, set underflow, pulse dac_valid with the underrun value, and move to UNDERRUN.
  - UNDERRUN: every strobe pulses dac_valid with the underrun value. Returns to RUN when level >= PREFILL; the first popped sample is the oldest FIFO entry.
- dac_valid cadence: exactly one pulse every RATE_DIV cycles in RUN and UNDERRUN; none in IDLE or PREFILL.
- dac_read: combinational from the registered level and enable. It is 0 in IDLE.
- Sticky bits and clr_status:
  - clr_status clears both sticky bits.
  - If a set condition and clr_status occur in the same cycle, the set wins.
- Reset mid-operation discards the FIFO contents and all status; the next cycle behaves as after power-up.
- Widths: no arithmetic is applied to the data; samples pass bit-exact.

Optional Feature:
UTIL_DAC_SAMPLE_BUF_HOLD_LAST_EN
- Defined: the underrun value repeats the last successfully popped sample; after reset or a flush, that value is 0.
- Undefined: the underrun value is 16'h0000 on both channels.
- Everything else is identical with or without the macro.

Test Plan:
- Reset/idle: hold reset 4 cycles, then enable=0 -> all outputs 0, dac_valid never pulses, dac_read=0.
- Prefill and stream:
  - Setup: enable=1, RATE_DIV=8; write 4 samples {16'h4000, 16'h2000} on consecutive cycles.
  - Required: RUN entered once level=4; dac_valid pulses every 8 cycles with dac_data_1=16'h4000, dac_data_0=16'h2000; underflow stays 0.
- Underflow:
  - Setup: prefill 4 samples of {16'h7FFF, 16'h3FFF}, then stop writing.
  - Required: 4 data pulses, and the 5th strobe sets underflow. Output on that strobe is 16'h0000 without the macro, {16'h7FFF, 16'h3FFF} with it. After 4 further writes, output resumes with those samples.
- Overflow and flow control:
  - Setup: in_valid held high for 20 cycles with an incrementing pattern.
  - Required: dac_read falls when level reaches 12; a write with level=16 and no pop sets overflow; popped data shows no gaps before the first dropped sample.
- Simultaneous events:
  - Setup: write on the same cycle as a pop at level=16.
  - Required: level stays 16 and overflow is not set.
  - Setup: clr_status coinciding with an underflow.
  - Required: underflow remains 1.
- Reset/disable mid-stream:
  - Setup: assert reset in RUN with level=6.
  - Required: next cycle level=0, state IDLE, sticky bits=0.
  - Setup: drop enable for 1 cycle.
  - Required: FIFO flushed, re-enters PREFILL.

Source files
------------

// File: rtl/util_dac_sample_buf.sv
// Elastic TX sample buffer between util_fir_int and the DAC: FIFO, fixed-rate strobe, sticky status.
// Optional macro UTIL_DAC_SAMPLE_BUF_HOLD_LAST_EN: underrun repeats the last popped sample.
module util_dac_sample_buf #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned RATE_DIV   = 8,
  parameter int unsigned PREFILL    = 4,
  parameter int unsigned HIGH_WM    = 12
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_valid,
  input  logic [15:0]           in_ch0,
  input  logic [15:0]           in_ch1,
  output logic                  dac_read,
  output logic                  dac_valid,
  output logic [15:0]           dac_data_0,
  output logic [15:0]           dac_data_1,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underflow,
  output logic                  overflow,
  input  logic                  clr_status
);

  localparam int unsigned Depth   = 2 ** DEPTH_LOG2;
  localparam int unsigned RateMax = RATE_DIV - 1;

  localparam logic [DEPTH_LOG2:0]   LvlFull    = Depth[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   LvlPrefill = PREFILL[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   LvlHighWm  = HIGH_WM[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   LvlOne     = 1;
  localparam logic [DEPTH_LOG2-1:0] PtrOne     = 1;
  localparam logic [7:0]            CntMax     = RateMax[7:0];

  typedef enum logic [1:0] {StIdle, StPrefill, StRun, StUnderrun} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2:0]     level_q, level_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [31:0]             mem_q [Depth];
  logic [31:0]             rd_data, urun_data, data_q;
  logic                    valid_q, uf_q, of_q, uf_d, of_d;
  logic                    full, empty, active, strobe, pop, push, emit, under_evt, ovf_evt;

  assign rd_data = mem_q[rd_ptr_q];

`ifdef UTIL_DAC_SAMPLE_BUF_HOLD_LAST_EN
  logic [31:0] last_q;

  always_ff @(posedge aclk) begin
    if (reset || !enable) begin
      last_q <= '0;
    end else if (pop) begin
      last_q <= rd_data;
    end
  end

  assign urun_data = last_q;
`else
  assign urun_data = '0;
`endif

  always_comb begin
    full      = (level_q == LvlFull);
    empty     = (level_q == '0);
    active    = (state_q == StRun) || (state_q == StUnderrun);
    strobe    = (state_q != StIdle) && (cnt_q == CntMax);
    emit      = enable && strobe && active;
    pop       = emit && (state_q == StRun) && !empty;
    under_evt = emit && empty;
    // A pop on the same edge frees the slot, so a write at full is still accepted.
    push      = enable && in_valid && (!full || pop);
    ovf_evt   = enable && in_valid && full && !pop;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LvlOne;
      2'b01:   level_d = level_q - LvlOne;
      default: level_d = level_q;
    endcase

    uf_d = under_evt ? 1'b1 : (clr_status ? 1'b0 : uf_q);
    of_d = ovf_evt   ? 1'b1 : (clr_status ? 1'b0 : of_q);

    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q != StIdle) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 8'd1;
    end
    case (state_q)
      StIdle:    state_d = StPrefill;
      StPrefill: begin
        if (level_q >= LvlPrefill) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun:      if (under_evt) state_d = StUnderrun;
      StUnderrun: if (level_q >= LvlPrefill) state_d = StRun;
      default:    state_d = StIdle;
    endcase
    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_ch1, in_ch0};
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      uf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= emit;
      uf_q    <= uf_d;
      of_q    <= of_d;
      if (!enable) begin
        level_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        level_q <= level_d;
        if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      if (pop) begin
        data_q <= rd_data;
      end else if (emit) begin
        data_q <= urun_data;
      end
    end
  end

  assign dac_read   = enable && (state_q != StIdle) && (level_q < LvlHighWm);
  assign dac_valid  = valid_q;
  assign dac_data_1 = data_q[31:16];
  assign dac_data_0 = data_q[15:0];
  assign level      = level_q;
  assign underflow  = uf_q;
  assign overflow   = of_q;

endmodule
